ace_read_snoop_ctrl: RTL and testbench

ACE_READ_SNOOP_CTRL -- requirements
Module: ace_read_snoop_ctrl

---
 rtl/ace_read_snoop_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ace_read_snoop_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_read_snoop_ctrl.sv
// ACE read front-end: snoops the peer cache on every supported read, falls back to
// memory when no snoop data is returned, and writes back dirty data a non-owning read leaves.
module ace_read_snoop_ctrl #(
    parameter int WIDTH_A = 32,
    parameter int WIDTH_D = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               AR_VALID,
    output logic               AR_READY,
    input  logic [WIDTH_A-1:0] AR_ADDR,
    input  logic               AR_ID,
    input  logic [3:0]         AR_SNOOP,
    output logic               R_VALID,
    input  logic               R_READY,
    output logic [WIDTH_D-1:0] RDATA,
    output logic               R_ID,
    output logic [3:0]         RRESP,
    output logic               R_LAST,
    output logic               AC_VALID,
    input  logic               AC_READY,
    output logic [WIDTH_A-1:0] AC_ADDR,
    output logic [3:0]         AC_SNOOP,
    input  logic               CR_VALID,
    output logic               CR_READY,
    input  logic [4:0]         CR_RESP,
    input  logic               CD_VALID,
    output logic               CD_READY,
    input  logic [WIDTH_D-1:0] CD_DATA,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic [WIDTH_A-1:0] mem_addr,
    output logic [WIDTH_D-1:0] mem_wdata,
    input  logic               mem_rvalid,
    input  logic [WIDTH_D-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, SNP_ADDR, SNP_RESP, SNP_DATA, MEM_RD, MEM_WB, RESP
    } state_t;

    localparam logic [3:0] READ_ONCE        = 4'b0000;
    localparam logic [3:0] READ_SHARED      = 4'b0001;
    localparam logic [3:0] READ_CLEAN       = 4'b0010;
    localparam logic [3:0] READ_NOT_SH_DIRT = 4'b0011;
    localparam logic [3:0] READ_UNIQUE      = 4'b0111;
    localparam logic [3:0] MAKE_UNIQUE      = 4'b1100;
    localparam logic [3:0] AC_MAKE_UNIQUE   = 4'b1101;

    state_t               state, next_state;
    logic [WIDTH_A-1:0]   addr_q;
    logic [WIDTH_D-1:0]   data_q;
    logic                 id_q;
    logic [3:0]           snoop_q;
    logic                 shared_q, dirty_q, err_q;
    logic                 from_snoop_q, unsup_q;
    logic                 ar_supported;
    logic                 is_make_unique;
    logic                 shared_type, dirty_type;
    logic [3:0]           rresp;
    logic                 was_unique_unused;

    // WasUnique carries no meaning for the read response
    assign was_unique_unused = CR_RESP[4];

    assign ar_supported = AR_SNOOP inside {READ_ONCE, READ_SHARED, READ_CLEAN,
                                           READ_NOT_SH_DIRT, READ_UNIQUE, MAKE_UNIQUE};
    assign is_make_unique = (snoop_q == MAKE_UNIQUE);
    assign shared_type = snoop_q inside {READ_SHARED, READ_CLEAN, READ_NOT_SH_DIRT};
    assign dirty_type  = snoop_q inside {READ_SHARED, READ_NOT_SH_DIRT, READ_UNIQUE};
    assign rresp = {shared_q & shared_type,
                    dirty_q & dirty_type & from_snoop_q,
                    unsup_q | err_q,
                    1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        AR_READY   = 1'b0;
        AC_VALID   = 1'b0;
        AC_ADDR    = '0;
        AC_SNOOP   = '0;
        CR_READY   = 1'b0;
        CD_READY   = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        R_VALID    = 1'b0;
        R_LAST     = 1'b0;
        RDATA      = '0;
        R_ID       = 1'b0;
        RRESP      = '0;
        case (state)
            IDLE: begin
                AR_READY = 1'b1;
                if (AR_VALID) next_state = ar_supported ? SNP_ADDR : RESP;
            end
            SNP_ADDR: begin
                AC_VALID = 1'b1;
                AC_ADDR  = addr_q;
                AC_SNOOP = is_make_unique ? AC_MAKE_UNIQUE : snoop_q;
                if (AC_READY) next_state = SNP_RESP;
            end
            SNP_RESP: begin
                CR_READY = 1'b1;
                if (CR_VALID) begin
                    if (CR_RESP[0])          next_state = SNP_DATA;
                    else if (is_make_unique) next_state = RESP;
                    else                     next_state = MEM_RD;
                end
            end
            SNP_DATA: begin
                CD_READY = 1'b1;
                // a non-owning read must not leave the only dirty copy behind
                if (CD_VALID) begin
                    if (dirty_q && (snoop_q == READ_ONCE || snoop_q == READ_CLEAN))
                        next_state = MEM_WB;
                    else
                        next_state = RESP;
                end
            end
            MEM_RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_q;
                if (mem_rvalid) next_state = RESP;
            end
            MEM_WB: begin
                mem_wr_en  = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = data_q;
                next_state = RESP;
            end
            RESP: begin
                R_VALID = 1'b1;
                R_LAST  = 1'b1;
                RDATA   = data_q;
                R_ID    = id_q;
                RRESP   = rresp;
                if (R_READY) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Per-transaction context; cleared at acceptance so unused fields read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            data_q       <= '0;
            id_q         <= 1'b0;
            snoop_q      <= '0;
            shared_q     <= 1'b0;
            dirty_q      <= 1'b0;
            err_q        <= 1'b0;
            from_snoop_q <= 1'b0;
            unsup_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (AR_VALID) begin
                    addr_q       <= AR_ADDR;
                    id_q         <= AR_ID;
                    snoop_q      <= AR_SNOOP;
                    unsup_q      <= ~ar_supported;
                    data_q       <= '0;
                    shared_q     <= 1'b0;
                    dirty_q      <= 1'b0;
                    err_q        <= 1'b0;
                    from_snoop_q <= 1'b0;
                end
                SNP_RESP: if (CR_VALID) begin
                    shared_q <= CR_RESP[3];
                    dirty_q  <= CR_RESP[2];
                    err_q    <= CR_RESP[1];
                end
                SNP_DATA: if (CD_VALID && !is_make_unique) begin
                    data_q       <= CD_DATA;
                    from_snoop_q <= 1'b1;
                end
                MEM_RD: if (mem_rvalid) data_q <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_read_snoop_ctrl.sv
// Randomized scoreboard bench for ace_read_snoop_ctrl: a reactive driver answers the
// snoop/memory side while a monitor checks every output handshake against a reference model.
module tb_ace_read_snoop_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        AR_VALID, AR_READY, AR_ID;
    logic [31:0] AR_ADDR;
    logic [3:0]  AR_SNOOP;
    logic        R_VALID, R_READY, R_ID, R_LAST;
    logic [31:0] RDATA;
    logic [3:0]  RRESP;
    logic        AC_VALID, AC_READY;
    logic [31:0] AC_ADDR;
    logic [3:0]  AC_SNOOP;
    logic        CR_VALID, CR_READY;
    logic [4:0]  CR_RESP;
    logic        CD_VALID, CD_READY;
    logic [31:0] CD_DATA;
    logic        mem_rd_en, mem_wr_en, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    ace_read_snoop_ctrl #(.WIDTH_A(32), .WIDTH_D(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_ID(AR_ID),
        .AR_SNOOP(AR_SNOOP),
        .R_VALID(R_VALID), .R_READY(R_READY), .RDATA(RDATA), .R_ID(R_ID), .RRESP(RRESP),
        .R_LAST(R_LAST),
        .AC_VALID(AC_VALID), .AC_READY(AC_READY), .AC_ADDR(AC_ADDR), .AC_SNOOP(AC_SNOOP),
        .CR_VALID(CR_VALID), .CR_READY(CR_READY), .CR_RESP(CR_RESP),
        .CD_VALID(CD_VALID), .CD_READY(CD_READY), .CD_DATA(CD_DATA),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        id;
        logic [3:0]  snoop;
        logic [4:0]  cr;
        logic [31:0] cd;
        logic [31:0] md;
        int          memDelay;
        int          rStall;
    } txn_t;

    typedef struct { logic [31:0] data; logic id; logic [3:0] resp; } rexp_t;
    typedef struct { logic [31:0] addr; logic [3:0] snoop; } acexp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wbexp_t;

    rexp_t       rQ[$];
    acexp_t      acQ[$];
    wbexp_t      wbQ[$];
    logic [31:0] rdQ[$];
    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the requester, snooped cache and memory should observe
    function automatic void predict(input txn_t t);
        rexp_t  r;
        acexp_t a;
        wbexp_t w;
        bit     sup, mu;
        sup = t.snoop inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hC};
        mu  = (t.snoop == 4'hC);
        r.id = t.id;
        if (!sup) begin
            r.data = 32'h0;
            r.resp = 4'b0010;
        end else begin
            a.addr  = t.addr;
            a.snoop = mu ? 4'hD : t.snoop;
            acQ.push_back(a);
            if (t.cr[0]) begin
                r.data = mu ? 32'h0 : t.cd;
                if (t.cr[2] && (t.snoop == 4'h0 || t.snoop == 4'h2)) begin
                    w.addr = t.addr;
                    w.data = t.cd;
                    wbQ.push_back(w);
                end
            end else if (mu) begin
                r.data = 32'h0;
            end else begin
                rdQ.push_back(t.addr);
                r.data = t.md;
            end
            r.resp[3]   = t.cr[3] && (t.snoop inside {4'h1, 4'h2, 4'h3});
            r.resp[2]   = t.cr[2] && t.cr[0] && (t.snoop inside {4'h1, 4'h3, 4'h7});
            r.resp[1:0] = t.cr[1] ? 2'b10 : 2'b00;
        end
        rQ.push_back(r);
    endfunction

    function automatic txn_t mk(input logic [31:0] addr, input logic [3:0] snoop,
                                input logic [4:0] cr, input logic [31:0] cd,
                                input logic [31:0] md, input int memDelay, input int rStall);
        txn_t t;
        t.addr = addr; t.id = addr[4]; t.snoop = snoop; t.cr = cr; t.cd = cd;
        t.md = md; t.memDelay = memDelay; t.rStall = rStall;
        return t;
    endfunction

    // Called #1 after a rising edge; reacts to whatever the DUT presents each cycle
    task automatic applyStimulus(input txn_t t);
        int cyc, memCnt, stallCnt;
        bit accepted, rHs;
        predict(t);
        AR_ADDR = t.addr; AR_ID = t.id; AR_SNOOP = t.snoop; AR_VALID = 1'b1;
        cyc = 0; accepted = 0;
        while (!accepted && cyc < 50) begin
            accepted = AR_READY;
            @(posedge clk); #1;
            cyc++;
        end
        AR_VALID = 1'b0;
        if (!accepted) begin
            checkOutput("ar_accept_timeout", 0, 1);
            return;
        end
        cyc = 0; memCnt = 0; stallCnt = 0; rHs = 0;
        while (!rHs && cyc < 300) begin
            AC_READY = AC_VALID && ($urandom_range(0, 1) == 1);
            CR_RESP  = t.cr;
            CR_VALID = CR_READY && ($urandom_range(0, 2) != 0);
            CD_DATA  = t.cd;
            CD_VALID = CD_READY && ($urandom_range(0, 2) != 0);
            mem_rdata = t.md;
            if (mem_rd_en) begin
                memCnt++;
                mem_rvalid = (memCnt > t.memDelay);
            end else begin
                memCnt = 0;
                mem_rvalid = 1'b0;
            end
            R_READY = 1'b0;
            if (R_VALID) begin
                if (stallCnt < t.rStall) begin
                    stallCnt++;
                    if (rQ.size() > 0) begin
                        checkOutput("stall_rdata", RDATA, rQ[0].data);
                        checkOutput("stall_rresp", RRESP, rQ[0].resp);
                        checkOutput("stall_rid", R_ID, rQ[0].id);
                    end
                    checkOutput("stall_ar_ready", AR_READY, 0);
                end else begin
                    R_READY = 1'b1;
                end
            end
            rHs = R_VALID && R_READY;
            @(posedge clk); #1;
            cyc++;
        end
        AC_READY = 0; CR_VALID = 0; CD_VALID = 0; mem_rvalid = 0; R_READY = 0;
        if (!rHs) checkOutput("r_timeout", 0, 1);
    endtask

    // Monitor: pops the scoreboard whenever a handshake or memory strobe is visible
    initial begin
        rexp_t  r;
        acexp_t a;
        wbexp_t w;
        logic [31:0] ra;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (R_VALID && R_READY) begin
                    if (rQ.size() == 0) checkOutput("unexpected_r", 1, 0);
                    else begin
                        r = rQ.pop_front();
                        checkOutput("rdata", RDATA, r.data);
                        checkOutput("rid", R_ID, r.id);
                        checkOutput("rresp", RRESP, r.resp);
                        checkOutput("rlast", R_LAST, 1);
                    end
                end
                if (AC_VALID && AC_READY) begin
                    if (acQ.size() == 0) checkOutput("unexpected_ac", 1, 0);
                    else begin
                        a = acQ.pop_front();
                        checkOutput("ac_addr", AC_ADDR, a.addr);
                        checkOutput("ac_snoop", AC_SNOOP, a.snoop);
                    end
                end
                if (mem_wr_en) begin
                    if (wbQ.size() == 0) checkOutput("unexpected_mem_wr", 1, 0);
                    else begin
                        w = wbQ.pop_front();
                        checkOutput("wb_addr", mem_addr, w.addr);
                        checkOutput("wb_data", mem_wdata, w.data);
                    end
                end
                if (mem_rd_en && mem_rvalid) begin
                    if (rdQ.size() == 0) checkOutput("unexpected_mem_rd", 1, 0);
                    else begin
                        ra = rdQ.pop_front();
                        checkOutput("rd_addr", mem_addr, ra);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] supList [6];
        txn_t t;
        int cyc;
        supList = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hC};
        rst_n = 1'b0;
        AR_VALID = 0; AR_ADDR = 0; AR_ID = 0; AR_SNOOP = 0; R_READY = 0;
        AC_READY = 0; CR_VALID = 0; CR_RESP = 0; CD_VALID = 0; CD_DATA = 0;
        mem_rvalid = 0; mem_rdata = 0;
        #12;
        checkOutput("reset_ar_ready", AR_READY, 1);
        checkOutput("reset_outputs_zero",
                    64'(|{AC_VALID, CR_READY, CD_READY, R_VALID, R_LAST, R_ID, mem_rd_en,
                          mem_wr_en, RDATA, RRESP, AC_ADDR, AC_SNOOP, mem_addr, mem_wdata}), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(mk(32'h40, 4'b0001, 5'b01001, 32'hCAFE, 32'hDEAD, 0, 0));
        applyStimulus(mk(32'h84, 4'b0111, 5'b00101, 32'h1234, 32'hDEAD, 0, 0));
        applyStimulus(mk(32'h90, 4'b0000, 5'b00101, 32'h55,   32'hDEAD, 0, 0));
        applyStimulus(mk(32'hA0, 4'b0010, 5'b00000, 32'hBEEF, 32'h77,   3, 0));
        applyStimulus(mk(32'hB0, 4'b1010, 5'b00000, 32'hBEEF, 32'h11,   0, 0));
        applyStimulus(mk(32'hC0, 4'b1100, 5'b00001, 32'h99,   32'h22,   0, 0));
        applyStimulus(mk(32'hD0, 4'b1100, 5'b00010, 32'h99,   32'h22,   0, 0));
        applyStimulus(mk(32'hE0, 4'b0011, 5'b01111, 32'h3C3C, 32'h22,   0, 5));

        for (int i = 0; i < 60; i++) begin
            t.snoop    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : supList[$urandom_range(0, 5)];
            t.addr     = $urandom;
            t.id       = 1'($urandom);
            t.cr       = 5'($urandom);
            t.cd       = $urandom;
            t.md       = $urandom;
            t.memDelay = $urandom_range(0, 4);
            t.rStall   = $urandom_range(0, 3);
            applyStimulus(t);
        end

        // Abort a ReadShared while it waits for the snoop response
        AR_ADDR = 32'h80; AR_ID = 1'b1; AR_SNOOP = 4'b0001; AR_VALID = 1'b1;
        begin
            acexp_t a;
            a.addr = 32'h80; a.snoop = 4'b0001;
            acQ.push_back(a);
        end
        cyc = 0;
        while (!AR_READY && cyc < 20) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        AR_VALID = 1'b0;
        cyc = 0;
        while (!CR_READY && cyc < 20) begin
            AC_READY = AC_VALID;
            @(posedge clk); #1;
            cyc++;
        end
        AC_READY = 1'b0;
        checkOutput("reached_snp_resp", CR_READY, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_ar_ready", AR_READY, 1);
        checkOutput("midreset_outputs_zero",
                    64'(|{AC_VALID, CR_READY, CD_READY, R_VALID, R_LAST, R_ID, mem_rd_en,
                          mem_wr_en, RDATA, RRESP, AC_ADDR, AC_SNOOP, mem_addr, mem_wdata}), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_idle", {AR_READY, CR_READY}, 2'b10);
        applyStimulus(mk(32'h44, 4'b0001, 5'b00000, 32'h0, 32'h5A5A, 1, 1));

        repeat (5) @(posedge clk);
        checkOutput("r_queue_empty", rQ.size(), 0);
        checkOutput("ac_queue_empty", acQ.size(), 0);
        checkOutput("wb_queue_empty", wbQ.size(), 0);
        checkOutput("rd_queue_empty", rdQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
